up_down_counter: RTL and testbench

- Dual 4-bit counter block: one register counts up from 0, a second counts down from max; `sel` picks which one advances, `enable` gates both.
- Sits in the timer/sequence-generation area as a simple event counter with terminal-count flags.
- Fully synchronous, single clock domain.

---
 rtl/up_down_counter_pkg.sv | 13 +
 rtl/up_down_counter_clk_div_tick.sv | 37 +++
 rtl/up_down_counter.sv | 76 +++++++
 tb/tb_up_down_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared constants and types for the dual up/down event counter.
// Optional prescaler build: UP_DOWN_COUNTER_CLK_DIV_EN.
package up_down_counter_pkg;

  localparam int unsigned WIDTH_DEF     = 4;
  localparam int unsigned DIV_RATIO_DEF = 4;

  typedef logic [WIDTH_DEF-1:0] count_t;

  localparam count_t UP_RST   = '0;
  localparam count_t DOWN_RST = '1;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_clk_div_tick.sv
// Prescaler: counts enabled cycles 0..DIV_RATIO-1 and flags the wrapping cycle.
// Instantiated only when UP_DOWN_COUNTER_CLK_DIV_EN is defined.
module clk_div_tick
  import up_down_counter_pkg::*;
#(
  parameter int unsigned DIV_RATIO = DIV_RATIO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CW = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Tick is high in the cycle whose edge wraps the prescaler back to 0.
  assign tick_c = enable && (cnt == CW'(DIV_RATIO - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (enable) begin
      cnt_nxt = tick_c ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule : clk_div_tick

// File: rtl/up_down_counter.sv
// Dual event counter: sel picks whether the up or the down register advances.
// Define UP_DOWN_COUNTER_CLK_DIV_EN to pace steps with a DIV_RATIO prescaler.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned DIV_RATIO = DIV_RATIO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sel,
  output logic [WIDTH-1:0] count_up,
  output logic [WIDTH-1:0] count_down,
  output logic             tc_up,
  output logic             tc_down
);

  // Reset words are uniform bit patterns, so they stretch to any WIDTH.
  localparam logic [WIDTH-1:0] UP_RST_W   = {WIDTH{UP_RST[0]}};
  localparam logic [WIDTH-1:0] DOWN_RST_W = {WIDTH{DOWN_RST[0]}};

  logic             step_c;
  logic [WIDTH-1:0] up_nxt;
  logic [WIDTH-1:0] down_nxt;

`ifdef UP_DOWN_COUNTER_CLK_DIV_EN
  logic div_tick_c;

  clk_div_tick #(
    .DIV_RATIO (DIV_RATIO)
  ) u_clk_div_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick_c (div_tick_c)
  );

  assign step_c = enable && div_tick_c;
`else
  assign step_c = enable;
`endif

  always_ff @(posedge clk) begin
    assert (DIV_RATIO >= 2) else $error("up_down_counter: DIV_RATIO must be >= 2");
  end

  // A non-1 sel (including X) falls through to the up-count branch.
  always_comb begin
    up_nxt   = count_up;
    down_nxt = count_down;
    if (step_c) begin
      if (sel) begin
        down_nxt = count_down - WIDTH'(1);
      end else begin
        up_nxt = count_up + WIDTH'(1);
      end
    end
  end

  // Flags decode the next count so they line up with the registers they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_up   <= UP_RST_W;
      count_down <= DOWN_RST_W;
      tc_up      <= 1'b0;
      tc_down    <= 1'b0;
    end else begin
      count_up   <= up_nxt;
      count_down <= down_nxt;
      tc_up      <= (up_nxt == '1);
      tc_down    <= (down_nxt == '0);
    end
  end

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: directed vector table, wrap
// sequences and randomized traffic against an arithmetic reference model.
module tb_up_down_counter;

  localparam int unsigned W    = 4;
  localparam int unsigned DIVR = 4;
  localparam int          MOD  = 1 << W;
`ifdef UP_DOWN_COUNTER_CLK_DIV_EN
  localparam int STEP_EVERY = DIVR;
`else
  localparam int STEP_EVERY = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         sel = 1'b0;
  logic [W-1:0] count_up;
  logic [W-1:0] count_down;
  logic         tc_up;
  logic         tc_down;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers, modulo arithmetic.
  int m_up   = 0;
  int m_down = MOD - 1;
  int m_pre  = 0;

  up_down_counter #(
    .WIDTH     (W),
    .DIV_RATIO (DIVR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sel        (sel),
    .count_up   (count_up),
    .count_down (count_down),
    .tc_up      (tc_up),
    .tc_down    (tc_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r;
    bit e;
    bit s;
    int exp_up;
    int exp_down;
    bit exp_tcu;
    bit exp_tcd;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit s);
    if (!r) begin
      m_up   = 0;
      m_down = MOD - 1;
      m_pre  = 0;
    end else if (e) begin
      m_pre++;
      if (m_pre == STEP_EVERY) begin
        m_pre = 0;
        if (s) m_down = (m_down + MOD - 1) % MOD;
        else   m_up   = (m_up + 1) % MOD;
      end
    end
  endtask

  // Drive on the falling edge, let one rising edge act, sample 1 time unit later.
  task automatic cycle(input bit r, input bit e, input bit s);
    @(negedge clk);
    rst = r; enable = e; sel = s;
    @(posedge clk);
    model_edge(r, e, s);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count_up"},   int'(count_up),   m_up);
    check({tag, ".count_down"}, int'(count_down), m_down);
    check({tag, ".tc_up"},      int'(tc_up),      int'(m_up == MOD - 1));
    check({tag, ".tc_down"},    int'(tc_down),    int'(r_is_reset() ? 1'b0 : (m_down == 0)));
  endtask

  function automatic bit r_is_reset();
    return 1'b0;
  endfunction

  initial begin
    vec_t vecs[$];

    // Reset state is checked the same way in both builds.
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check("reset.count_up",   int'(count_up),   0);
    check("reset.count_down", int'(count_down), 15);
    check("reset.tc_up",      int'(tc_up),      0);
    check("reset.tc_down",    int'(tc_down),    0);

`ifndef UP_DOWN_COUNTER_CLK_DIV_EN
    vecs.push_back('{1, 1, 0,  1, 15, 0, 0});
    vecs.push_back('{1, 1, 0,  2, 15, 0, 0});
    vecs.push_back('{1, 1, 0,  3, 15, 0, 0});
    vecs.push_back('{1, 1, 1,  3, 14, 0, 0});
    vecs.push_back('{1, 1, 1,  3, 13, 0, 0});
    vecs.push_back('{1, 0, 0,  3, 13, 0, 0});
    vecs.push_back('{1, 0, 1,  3, 13, 0, 0});
    vecs.push_back('{1, 0, 0,  3, 13, 0, 0});
    vecs.push_back('{1, 0, 1,  3, 13, 0, 0});
    vecs.push_back('{1, 0, 0,  3, 13, 0, 0});
    vecs.push_back('{0, 1, 1,  0, 15, 0, 0});
    vecs.push_back('{1, 1, 1,  0, 14, 0, 0});
    vecs.push_back('{1, 1, 0,  1, 14, 0, 0});
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].e, vecs[i].s);
      check($sformatf("vec%0d.count_up", i),   int'(count_up),   vecs[i].exp_up);
      check($sformatf("vec%0d.count_down", i), int'(count_down), vecs[i].exp_down);
      check($sformatf("vec%0d.tc_up", i),      int'(tc_up),      int'(vecs[i].exp_tcu));
      check($sformatf("vec%0d.tc_down", i),    int'(tc_down),    int'(vecs[i].exp_tcd));
    end

    // Up wrap: 15 steps from 0 reach all ones, the 16th returns to 0.
    cycle(0, 1, 0);
    for (int i = 0; i < 15; i++) cycle(1, 1, 0);
    check("wrap_up.at_max",   int'(count_up), 15);
    check("wrap_up.tc_high",  int'(tc_up),    1);
    cycle(1, 1, 0);
    check("wrap_up.to_zero",  int'(count_up), 0);
    check("wrap_up.tc_low",   int'(tc_up),    0);

    // Down wrap: 15 steps from all ones reach 0, the next returns to all ones.
    for (int i = 0; i < 15; i++) cycle(1, 1, 1);
    check("wrap_down.at_zero",  int'(count_down), 0);
    check("wrap_down.tc_high",  int'(tc_down),    1);
    check("wrap_down.up_holds", int'(count_up),   0);
    cycle(1, 1, 1);
    check("wrap_down.to_max",   int'(count_down), 15);
    check("wrap_down.tc_low",   int'(tc_down),    0);
`else
    // Prescaled: one up step per DIVR enabled cycles after reset.
    for (int i = 1; i <= 2 * DIVR; i++) begin
      cycle(1, 1, 0);
      check($sformatf("div.edge%0d.count_up", i), int'(count_up), i / DIVR);
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    check("div.hold.count_up", int'(count_up), 2);
    for (int i = 0; i < DIVR; i++) cycle(1, 1, 1);
    check("div.down.count_down", int'(count_down), 14);
    check("div.down.count_up",   int'(count_up),   2);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit e;
      bit s;
      r = ($urandom_range(0, 31) != 0);
      e = ($urandom_range(0, 3) != 0);
      s = 1'($urandom_range(0, 1));
      cycle(r, e, s);
      check_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_up_down_counter
